// File: rtl/score_digit_renderer_pkg.sv
// Shared constants, converter state type and sizing helpers for the score
// digit renderer and its BCD converter.
package score_digit_renderer_pkg;

    localparam logic [3:0] BLANK_DIGIT = 4'd15;
    localparam int FONT_W = 8;
    localparam int FONT_H = 8;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } conv_state_e;

    function automatic int bcd_w(input int n);
        return 4 * n;
    endfunction

    function automatic longint unsigned max_decimal(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/score_digit_renderer_bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter with saturation to all-9s.
// done is high for exactly the cycle in which bcd_out holds the final result.
module bin2bcd_seq
    import score_digit_renderer_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [SCORE_W-1:0]               score,
    output logic                             busy,
    output logic [bcd_w(NUM_DIGITS)-1:0]     bcd_out,
    output logic                             done
);

    localparam int BW = bcd_w(NUM_DIGITS);
    localparam int CW = $clog2(SCORE_W + 1);
    localparam longint unsigned MAX_SCORE = max_decimal(NUM_DIGITS);

    conv_state_e        state_reg;
    logic [BW-1:0]      bcd_reg;
    logic [BW-1:0]      bcd_adj;
    logic [BW-1:0]      all_nines;
    logic [SCORE_W-1:0] shift_reg;
    logic [CW-1:0]      cnt_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               saturate;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
        assign all_nines[4*gi +: 4] = 4'd9;
    end

    assign saturate = 64'(score) > MAX_SCORE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            bcd_reg   <= '0;
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (saturate) begin
                            // Out-of-range scores skip conversion entirely.
                            bcd_reg   <= all_nines;
                            done_reg  <= 1'b1;
                            state_reg <= COMMIT;
                        end else begin
                            bcd_reg   <= '0;
                            shift_reg <= score;
                            cnt_reg   <= CW'(SCORE_W);
                            state_reg <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        done_reg  <= 1'b1;
                        state_reg <= COMMIT;
                    end
                end
                COMMIT: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy    = busy_reg;
    assign bcd_out = bcd_reg;
    assign done    = done_reg;

endmodule

// File: rtl/score_digit_renderer.sv
// Score overlay: accepts a binary score, holds its BCD digits for display and
// runs a 2-stage pixel pipeline through an external combinational font ROM.
module score_digit_renderer
    import score_digit_renderer_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4,
    parameter int X0         = 16,
    parameter int Y0         = 16,
    parameter int SCALE_SH   = 1,
    parameter int LZ_BLANK   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic               pix_valid_in,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    output logic [3:0]         rom_digit,
    output logic [2:0]         rom_row,
    input  logic [7:0]         rom_bitmap,
    output logic               pixel_on,
    output logic               pixel_valid
);

    localparam int BW    = bcd_w(NUM_DIGITS);
    localparam int GLYPH = FONT_W << SCALE_SH;
    localparam logic [10:0] FIELD_W = 11'(NUM_DIGITS * GLYPH);
    localparam logic [10:0] FIELD_H = 11'(FONT_H << SCALE_SH);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic          conv_busy;
    logic          conv_done;
    logic [BW-1:0] conv_bcd;
    logic [BW-1:0] display_reg;

    bin2bcd_seq #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (score_valid),
        .score   (score_in),
        .busy    (conv_busy),
        .bcd_out (conv_bcd),
        .done    (conv_done)
    );

    assign score_ready = ~conv_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_reg <= '0;
        end else if (conv_done) begin
            display_reg <= conv_bcd;
        end
    end

    // Glyph code per screen position; position 0 is the most significant digit.
    logic [3:0] glyph_code [NUM_DIGITS];
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_glyph
        logic lead_zero;
        assign lead_zero = (display_reg[BW-1 -: 4*(gi+1)] == '0);
        assign glyph_code[gi] = ((LZ_BLANK != 0) && (gi != NUM_DIGITS - 1) && lead_zero) ?
                                BLANK_DIGIT : display_reg[4*(NUM_DIGITS-1-gi) +: 4];
    end

    logic [9:0]    dx;
    logic [9:0]    dy;
    logic          in_field;
    logic [DW-1:0] dig_idx;
    logic [2:0]    row_sel;
    logic [2:0]    col_sel;
    logic [2:0]    col_reg;
    logic          s1_valid_reg;

    assign dx       = pixel_x - 10'(X0);
    assign dy       = pixel_y - 10'(Y0);
    assign in_field = (pixel_x >= 10'(X0)) && ({1'b0, dx} < FIELD_W) &&
                      (pixel_y >= 10'(Y0)) && ({1'b0, dy} < FIELD_H);
    assign dig_idx  = DW'(dx >> (SCALE_SH + 3));
    assign row_sel  = 3'(FONT_H - 1) - 3'(dy >> SCALE_SH);
    assign col_sel  = 3'(dx >> SCALE_SH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_digit    <= BLANK_DIGIT;
            rom_row      <= '0;
            col_reg      <= '0;
            s1_valid_reg <= 1'b0;
            pixel_on     <= 1'b0;
            pixel_valid  <= 1'b0;
        end else begin
            s1_valid_reg <= pix_valid_in;
            if (pix_valid_in) begin
                rom_digit <= in_field ? glyph_code[dig_idx] : BLANK_DIGIT;
                rom_row   <= row_sel;
                col_reg   <= col_sel;
            end else begin
                rom_digit <= BLANK_DIGIT;
            end
            // The ROM answers the blank code with zeros, so no extra gating.
            pixel_on    <= rom_bitmap[3'd7 - col_reg];
            pixel_valid <= s1_valid_reg;
        end
    end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer with a font ROM model and an
// arithmetic reference of what each screen pixel should show.
module tb_score_digit_renderer;

    localparam int SCORE_W  = 14;
    localparam int ND       = 4;
    localparam int X0       = 16;
    localparam int Y0       = 16;
    localparam int SCALE_SH = 1;
    localparam int LZ_BLANK = 1;
    localparam int GLYPH    = 8 << SCALE_SH;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [SCORE_W-1:0] score_in = '0;
    logic               score_valid = 1'b0;
    logic               score_ready;
    logic               pix_valid_in = 1'b0;
    logic [9:0]         pixel_x = '0;
    logic [9:0]         pixel_y = '0;
    logic [3:0]         rom_digit;
    logic [2:0]         rom_row;
    logic [7:0]         rom_bitmap;
    logic               pixel_on;
    logic               pixel_valid;

    logic [7:0] font [0:127];
    int checks = 0;
    int failures = 0;
    int model_score = 0;

    always #5 clk = ~clk;

    always_comb begin
        rom_bitmap = 8'h00;
        if (rom_digit != 4'd15) rom_bitmap = font[{rom_digit, rom_row}];
    end

    score_digit_renderer #(
        .SCORE_W(SCORE_W), .NUM_DIGITS(ND), .X0(X0), .Y0(Y0),
        .SCALE_SH(SCALE_SH), .LZ_BLANK(LZ_BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .score_in(score_in), .score_valid(score_valid),
        .score_ready(score_ready), .pix_valid_in(pix_valid_in), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .rom_digit(rom_digit), .rom_row(rom_row),
        .rom_bitmap(rom_bitmap), .pixel_on(pixel_on), .pixel_valid(pixel_valid)
    );

    function automatic bit inside_field(int x, int y);
        return (x >= X0) && (y >= Y0) && (x - X0 < ND * GLYPH) && (y - Y0 < GLYPH);
    endfunction

    function automatic int exp_digit(int x, int y, int sc);
        int d, pw;
        if (!inside_field(x, y)) return 15;
        d = (x - X0) / GLYPH;
        pw = 1;
        for (int i = 0; i < ND - 1 - d; i++) pw = pw * 10;
        if (LZ_BLANK != 0 && d != ND - 1 && sc < pw) return 15;
        return (sc / pw) % 10;
    endfunction

    function automatic int exp_row(int y);
        return 7 - (((y - Y0) / (1 << SCALE_SH)) % 8);
    endfunction

    function automatic bit exp_on(int x, int y, int sc);
        int dig;
        logic [7:0] b;
        dig = exp_digit(x, y, sc);
        if (dig == 15) return 1'b0;
        b = font[dig * 8 + exp_row(y)];
        return b[7 - (((x - X0) / (1 << SCALE_SH)) % 8)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input logic v);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        pix_valid_in = v;
    endtask

    task automatic send_score(input int val);
        int n;
        n = 0;
        while (score_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (score_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake_timeout score_ready=%b required=1", score_ready);
        end
        score_valid = 1'b1;
        score_in = SCORE_W'(val);
        tick();
        score_valid = 1'b0;
        $display("score %0d sent", val);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", score_ready); end
        checks++;
        if (pixel_valid !== 1'b0) begin failures++; $display("FAIL reset_pixel_valid got=%b required=0", pixel_valid); end
        checks++;
        if (pixel_on !== 1'b0) begin failures++; $display("FAIL reset_pixel_on got=%b required=0", pixel_on); end
        checks++;
        if (rom_digit !== 4'd15) begin failures++; $display("FAIL reset_rom_digit got=%0d required=15", rom_digit); end
        checks++;
        if (rom_row !== 3'd0) begin failures++; $display("FAIL reset_rom_row got=%0d required=0", rom_row); end
        rst_n = 1'b1;
        model_score = 0;
        tick();
    endtask

    task automatic test_initial_pixel();
        int x, y;
        font[6] = 8'h42;
        x = X0 + 3 * GLYPH + 2;
        y = Y0 + 2;
        set_pix(x, y, 1'b1);
        tick();
        pix_valid_in = 1'b0;
        checks++;
        if (rom_digit !== 4'(exp_digit(x, y, model_score))) begin
            failures++; $display("FAIL init_rom_digit got=%0d required=%0d", rom_digit, exp_digit(x, y, model_score));
        end
        checks++;
        if (rom_row !== 3'(exp_row(y))) begin
            failures++; $display("FAIL init_rom_row got=%0d required=%0d", rom_row, exp_row(y));
        end
        tick();
        checks++;
        if (pixel_on !== exp_on(x, y, model_score)) begin
            failures++; $display("FAIL init_pixel_on got=%b required=%b", pixel_on, exp_on(x, y, model_score));
        end
        checks++;
        if (pixel_valid !== 1'b1) begin failures++; $display("FAIL init_pixel_valid got=%b required=1", pixel_valid); end
        for (int d = 0; d < 3; d++) begin
            set_pix(X0 + d * GLYPH + 2, Y0 + 2, 1'b1);
            tick();
            checks++;
            if (rom_digit !== 4'(exp_digit(X0 + d * GLYPH + 2, Y0 + 2, model_score))) begin
                failures++; $display("FAIL init_blank_digit d=%0d got=%0d required=15", d, rom_digit);
            end
        end
        pix_valid_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_convert();
        send_score(1234);
        for (int k = 1; k <= 15; k++) begin
            checks++;
            if (score_ready !== 1'b0) begin failures++; $display("FAIL convert_ready_low k=%0d got=%b required=0", k, score_ready); end
            if (k == 15) set_pix(X0 + 2, Y0 + 2, 1'b1);
            tick();
        end
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL convert_ready_high got=%b required=1", score_ready); end
        checks++;
        if (rom_digit !== 4'(exp_digit(X0 + 2, Y0 + 2, model_score))) begin
            failures++; $display("FAIL convert_commit_old got=%0d required=%0d", rom_digit, exp_digit(X0 + 2, Y0 + 2, model_score));
        end
        model_score = 1234;
        for (int d = 0; d < ND; d++) begin
            set_pix(X0 + d * GLYPH + 3, Y0, 1'b1);
            tick();
            checks++;
            if (rom_digit !== 4'(exp_digit(X0 + d * GLYPH + 3, Y0, model_score))) begin
                failures++; $display("FAIL convert_digit d=%0d got=%0d required=%0d", d, rom_digit, exp_digit(X0 + d * GLYPH + 3, Y0, model_score));
            end
            checks++;
            if (rom_row !== 3'd7) begin failures++; $display("FAIL convert_top_row d=%0d got=%0d required=7", d, rom_row); end
        end
        pix_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_saturate(input int val);
        int old;
        old = model_score;
        send_score(val);
        checks++;
        if (score_ready !== 1'b0) begin failures++; $display("FAIL sat_ready_t1 val=%0d got=%b required=0", val, score_ready); end
        set_pix(X0 + 2, Y0 + 2, 1'b1);
        tick();
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL sat_ready_t2 val=%0d got=%b required=1", val, score_ready); end
        checks++;
        if (rom_digit !== 4'(exp_digit(X0 + 2, Y0 + 2, old))) begin
            failures++; $display("FAIL sat_commit_old val=%0d got=%0d required=%0d", val, rom_digit, exp_digit(X0 + 2, Y0 + 2, old));
        end
        model_score = (val > 9999) ? 9999 : val;
        for (int d = 0; d < ND; d++) begin
            set_pix(X0 + d * GLYPH + 5, Y0 + 9, 1'b1);
            tick();
            checks++;
            if (rom_digit !== 4'(exp_digit(X0 + d * GLYPH + 5, Y0 + 9, model_score))) begin
                failures++; $display("FAIL sat_digit val=%0d d=%0d got=%0d required=%0d", val, d, rom_digit, exp_digit(X0 + d * GLYPH + 5, Y0 + 9, model_score));
            end
        end
        pix_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_ignore_during_convert();
        send_score(4096);
        score_valid = 1'b1;
        score_in = SCORE_W'(77);
        for (int k = 1; k <= 15; k++) begin
            checks++;
            if (score_ready !== 1'b0) begin failures++; $display("FAIL ignore_ready_low k=%0d got=%b required=0", k, score_ready); end
            tick();
        end
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL ignore_ready_high got=%b required=1", score_ready); end
        model_score = 4096;
        set_pix(X0 + 2, Y0 + 2, 1'b1);
        tick();
        score_valid = 1'b0;
        $display("score 77 sent");
        checks++;
        if (score_ready !== 1'b0) begin failures++; $display("FAIL ignore_second_accept got=%b required=0", score_ready); end
        checks++;
        if (rom_digit !== 4'(exp_digit(X0 + 2, Y0 + 2, model_score))) begin
            failures++; $display("FAIL ignore_first_score got=%0d required=%0d", rom_digit, exp_digit(X0 + 2, Y0 + 2, model_score));
        end
        pix_valid_in = 1'b0;
        for (int n = 0; n < 100 && score_ready !== 1'b1; n++) tick();
        model_score = 77;
        for (int d = 0; d < ND; d++) begin
            set_pix(X0 + d * GLYPH + 7, Y0 + 12, 1'b1);
            tick();
            checks++;
            if (rom_digit !== 4'(exp_digit(X0 + d * GLYPH + 7, Y0 + 12, model_score))) begin
                failures++; $display("FAIL ignore_second_digit d=%0d got=%0d required=%0d", d, rom_digit, exp_digit(X0 + d * GLYPH + 7, Y0 + 12, model_score));
            end
        end
        pix_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int x;
        x = X0 + 3 * GLYPH + 2;
        set_pix(x, Y0 + 2, 1'b1);
        send_score(4321);
        repeat (4) tick();
        checks++;
        if (rom_digit !== 4'(exp_digit(x, Y0 + 2, model_score))) begin
            failures++; $display("FAIL rstmid_pre_digit got=%0d required=%0d", rom_digit, exp_digit(x, Y0 + 2, model_score));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b required=1", score_ready); end
        checks++;
        if (pixel_valid !== 1'b0) begin failures++; $display("FAIL rstmid_pixel_valid got=%b required=0", pixel_valid); end
        checks++;
        if (rom_digit !== 4'd15) begin failures++; $display("FAIL rstmid_rom_digit got=%0d required=15", rom_digit); end
        tick();
        tick();
        rst_n = 1'b1;
        model_score = 0;
        tick();
        checks++;
        if (rom_digit !== 4'(exp_digit(x, Y0 + 2, model_score))) begin
            failures++; $display("FAIL rstmid_post_digit got=%0d required=%0d", rom_digit, exp_digit(x, Y0 + 2, model_score));
        end
        set_pix(X0 + 2 * GLYPH + 2, Y0 + 2, 1'b1);
        tick();
        checks++;
        if (rom_digit !== 4'(exp_digit(X0 + 2 * GLYPH + 2, Y0 + 2, model_score))) begin
            failures++; $display("FAIL rstmid_post_blank got=%0d required=15", rom_digit);
        end
        pix_valid_in = 1'b0;
        tick();
        checks++;
        if (score_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_after got=%b required=1", score_ready); end
    endtask

    task automatic test_boundaries();
        int bx [5];
        int by [5];
        send_score(8888);
        for (int n = 0; n < 100 && score_ready !== 1'b1; n++) tick();
        model_score = 8888;
        bx = '{X0 - 1, X0 + 64, X0 + 50, X0 + 2, X0 + 63};
        by = '{Y0 + 2, Y0 + 2, Y0 + 16, Y0 - 1, Y0 + 15};
        for (int i = 0; i < 5; i++) begin
            set_pix(bx[i], by[i], 1'b1);
            tick();
            pix_valid_in = 1'b0;
            checks++;
            if (rom_digit !== 4'(exp_digit(bx[i], by[i], model_score))) begin
                failures++; $display("FAIL bound_digit x=%0d y=%0d got=%0d required=%0d", bx[i], by[i], rom_digit, exp_digit(bx[i], by[i], model_score));
            end
            tick();
            checks++;
            if (pixel_on !== exp_on(bx[i], by[i], model_score)) begin
                failures++; $display("FAIL bound_pixel_on x=%0d y=%0d got=%b required=%b", bx[i], by[i], pixel_on, exp_on(bx[i], by[i], model_score));
            end
        end
        // Last column of the last digit at the glyph top: only bit 0 matters.
        for (int i = 0; i < 2; i++) begin
            font[8 * 8 + 7] = (i == 0) ? 8'h01 : 8'hFE;
            set_pix(X0 + 63, Y0, 1'b1);
            tick();
            pix_valid_in = 1'b0;
            checks++;
            if (rom_row !== 3'd7) begin failures++; $display("FAIL bound_last_row got=%0d required=7", rom_row); end
            tick();
            checks++;
            if (pixel_on !== exp_on(X0 + 63, Y0, model_score)) begin
                failures++; $display("FAIL bound_last_col pattern=%0d got=%b required=%b", i, pixel_on, exp_on(X0 + 63, Y0, model_score));
            end
        end
    endtask

    task automatic test_back_to_back();
        int sc;
        int h1x, h1y, h2x, h2y;
        logic h1v, h2v;
        int x, y;
        logic v;
        for (int r = 0; r < 3; r++) begin
            sc = (r == 0) ? int'($urandom_range(0, 99)) :
                 (r == 1) ? int'($urandom_range(100, 9999)) : int'($urandom_range(0, 16383));
            send_score(sc);
            for (int n = 0; n < 100 && score_ready !== 1'b1; n++) tick();
            model_score = (sc > 9999) ? 9999 : sc;
            pix_valid_in = 1'b0;
            tick();
            tick();
            h1v = 1'b0; h2v = 1'b0; h1x = 0; h1y = 0; h2x = 0; h2y = 0;
            for (int c = 0; c < 150; c++) begin
                x = int'($urandom_range(0, 90));
                y = int'($urandom_range(8, 40));
                v = ($urandom_range(0, 3) != 0);
                set_pix(x, y, v);
                tick();
                h2v = h1v; h2x = h1x; h2y = h1y;
                h1v = v;   h1x = x;   h1y = y;
                checks++;
                if (rom_digit !== (h1v ? 4'(exp_digit(h1x, h1y, model_score)) : 4'd15)) begin
                    failures++; $display("FAIL b2b_rom_digit x=%0d y=%0d v=%b got=%0d required=%0d", h1x, h1y, h1v, rom_digit, h1v ? exp_digit(h1x, h1y, model_score) : 15);
                end
                if (h1v && inside_field(h1x, h1y)) begin
                    checks++;
                    if (rom_row !== 3'(exp_row(h1y))) begin
                        failures++; $display("FAIL b2b_rom_row y=%0d got=%0d required=%0d", h1y, rom_row, exp_row(h1y));
                    end
                end
                checks++;
                if (pixel_valid !== h2v) begin
                    failures++; $display("FAIL b2b_pixel_valid got=%b required=%b", pixel_valid, h2v);
                end
                checks++;
                if (pixel_on !== (h2v ? exp_on(h2x, h2y, model_score) : 1'b0)) begin
                    failures++; $display("FAIL b2b_pixel_on x=%0d y=%0d got=%b required=%b", h2x, h2y, pixel_on, h2v ? exp_on(h2x, h2y, model_score) : 1'b0);
                end
            end
            pix_valid_in = 1'b0;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) font[i] = 8'($urandom);
        test_reset();
        test_initial_pixel();
        test_convert();
        test_saturate(12000);
        test_saturate(16383);
        test_ignore_during_convert();
        test_reset_mid();
        test_boundaries();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_digit_renderer.md
Name: score_digit_renderer

Overview:
- Renders an unsigned binary score as NUM_DIGITS decimal glyphs inside a fixed screen rectangle for the VGA overlay path.
- Accepts a new score through a valid/ready handshake and converts it to BCD sequentially (shift-add-3).
- Per pixel, sequences the shared combinational digit font ROM (digit, row) -> 8-bit row bitmap and returns a registered pixel_on bit.
- Sits between the score logic and the pixel mixer.

Parameters:
- SCORE_W, 14, width of binary score input.
- NUM_DIGITS, 4, number of displayed decimal digits.
- X0, 16, left pixel column of the digit field.
- Y0, 16, top pixel row of the digit field.
- SCALE_SH, 1, glyph magnification = 2^SCALE_SH. Each glyph is 8<<SCALE_SH pixels square.
- LZ_BLANK, 1, when 1, leading zeros are blanked; the least-significant digit is never blanked.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- score_in  in  SCORE_W  binary score.
- score_valid  in  1  score_in is valid.
- score_ready  out  1  converter idle; the score is accepted when valid && ready.
- pix_valid_in  in  1  pixel_x/pixel_y valid this cycle.
- pixel_x  in  10  current pixel column.
- pixel_y  in  10  current pixel row.
- rom_digit  out  4  font ROM digit select. 4'd15 is the blank code; the ROM returns all zeros for it.
- rom_row  out  3  font ROM row select. Row 7 is the glyph top.
- rom_bitmap  in  8  font ROM row data. Bit 7 is the leftmost pixel.
- pixel_on  out  1  glyph pixel lit.
- pixel_valid  out  1  pixel_on corresponds to a pix_valid_in two cycles earlier.

Behaviour:
Reset:
- Asynchronous, active-low. Sets state IDLE, score_ready=1, and display BCD to all zeros (shows "0" when LZ_BLANK=1).
- rom_digit=15, rom_row=0, pixel_on=0, pixel_valid=0.

Converter FSM (IDLE, CONVERT, COMMIT):
- IDLE: score_ready=1. On score_valid && score_ready at cycle t:
  - Latch the score.
  - If score_in > 10^NUM_DIGITS-1, saturate to all-9s BCD.
  - Go to CONVERT with a bit counter of SCORE_W.
- CONVERT: score_ready=0.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the next score MSB.
  - Lasts exactly SCORE_W cycles (t+1..t+SCORE_W).
  - score_valid is ignored in this state; there is no queueing.
- COMMIT (cycle t+SCORE_W+1):
  - Copy the working BCD to the display BCD register in one cycle.
  - score_ready=1 from t+SCORE_W+2.
- The display register never shows a partial conversion.
- Saturated scores skip CONVERT: all-9s is committed at t+1.
- Reset mid-conversion aborts the conversion. Display returns to 0.

Pixel pipeline (2-cycle latency):
- Stage 1, registered on pix_valid_in:
  - dx = pixel_x - X0, dy = pixel_y - Y0, computed unsigned with an underflow check.
  - Inside iff pixel_x >= X0, dx < NUM_DIGITS*(8<<SCALE_SH), pixel_y >= Y0, and dy < (8<<SCALE_SH).
  - Digit index d = dx >> (SCALE_SH+3). Digit 0 is the leftmost, i.e. the most significant.
  - rom_row = 7 - ((dy >> SCALE_SH) & 7).
  - col = (dx >> SCALE_SH) & 7 is held in a register.
  - rom_digit = display nibble for d, or 15 if outside the field or the digit is a blanked leading zero.
  - Leading zero: all more-significant nibbles are zero and d != NUM_DIGITS-1.
  - When pix_valid_in=0, hold rom_digit=15.
- Stage 2:
  - pixel_on <= rom_bitmap[7-col]. This is 0 when rom_digit was 15.
  - pixel_valid <= the stage-1 valid.
- Back-to-back pixels every cycle are supported.
- A COMMIT in the same cycle as a stage-1 lookup: that lookup uses the old display value; the next pixel uses the new one.

Decomposition:
- Shared package holds:
  - BLANK_DIGIT = 4'd15.
  - FONT_W = 8, FONT_H = 8.
  - BCD_W(n) = 4*n.
  - Function max_decimal(n) = 10^n-1.
- Sub-module bin2bcd_seq: parameterised SCORE_W/NUM_DIGITS sequential converter. It owns the IDLE/CONVERT/COMMIT FSM and the saturation logic, and exposes start/busy/bcd_out/done.
- The top level holds the pixel pipeline and the ROM interface.
- The font ROM is instantiated outside this block and connected by the parent.

Test Plan:
1. After reset, no score: a pixel at (X0+3*16+2, Y0+2) with SCALE_SH=1 -> rom_digit=0 and rom_row=6 one cycle after pix_valid_in. With the ROM model returning 0x42, col=1 gives pixel_on=1 at two cycles. Digits 0-2 are driven as 15 (blanked).
2. score_in=1234 accepted at cycle t:
   - score_ready low t+1..t+15.
   - Display nibbles {1,2,3,4} visible at t+16; ready high at t+16.
   - A pixel in digit 1, top row -> rom_digit=2, rom_row=7.
3. score_in=12000 (>9999) -> display 9999 committed at t+1, ready high at t+2. score_in=16383 gives the same result.
4. score_valid held high during CONVERT with score_in=77 -> ignored. The display shows the first score only, and a second handshake occurs only when ready=1.
5. Reset asserted at t+5 of a conversion of 4321:
   - score_ready=1, pixel_valid=0, rom_digit=15 immediately.
   - After release, the display shows "0".
6. Boundaries: pixels at x=X0-1, x=X0+64, y=Y0+16 -> rom_digit=15 and pixel_on=0. x=X0+63 -> last column of digit 3, col=7, bit 0 of rom_bitmap selected.
